// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_gen
// Brief    : Step/direction pulse generator with direction setup, fixed-rate
//            full-width pulses and a wrapping signed step-position counter.
// Revision : 1.0 - initial release
// ============================================================================
module step_pulse_gen #(
  parameter int PERIOD    = 5000,
  parameter int PUL_HIGH  = 2500,
  parameter int DIR_SETUP = 250,
  parameter int POS_W     = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena_in,
  input  logic                    dir_in,
  input  logic                    pos_clr,
  output logic                    ENA,
  output logic                    DIR,
  output logic                    PUL,
  output logic                    step_stb,
  output logic signed [POS_W-1:0] position
);

  localparam int c_MAX_LEN = (PERIOD > DIR_SETUP) ? PERIOD : DIR_SETUP;
  localparam int c_CNT_W   = $clog2(c_MAX_LEN + 1);

  // Counter holds "cycles remaining minus one", so zero marks the last cycle.
  localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(DIR_SETUP - 1);
  localparam logic [c_CNT_W-1:0] c_HIGH_LD  = c_CNT_W'(PUL_HIGH - 1);
  localparam logic [c_CNT_W-1:0] c_LOW_LD   = c_CNT_W'(PERIOD - PUL_HIGH - 1);
  localparam logic signed [POS_W-1:0] c_ONE = POS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                w_expired;
  logic                w_dir_match;
  logic                w_to_high;
  logic                w_to_setup;

  assign w_expired   = (r_cnt == '0);
  assign w_dir_match = (dir_in == DIR);

  always_comb begin
    w_to_high  = 1'b0;
    w_to_setup = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_to_high  = ena_in &  w_dir_match;
        w_to_setup = ena_in & ~w_dir_match;
      end
      S_SETUP: w_to_high = w_expired;
      S_LOW: begin
        w_to_high  = w_expired & ena_in &  w_dir_match;
        w_to_setup = w_expired & ena_in & ~w_dir_match;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      ENA      <= 1'b0;
      DIR      <= 1'b0;
      PUL      <= 1'b0;
      step_stb <= 1'b0;
      position <= '0;
    end else begin
      step_stb <= w_to_high;

      if (w_to_high) begin
        r_state <= S_HIGH;
        r_cnt   <= c_HIGH_LD;
        ENA     <= 1'b1;
        PUL     <= 1'b1;
      end else if (w_to_setup) begin
        r_state <= S_SETUP;
        r_cnt   <= c_SETUP_LD;
        ENA     <= 1'b1;
        PUL     <= 1'b0;
        DIR     <= dir_in;
      end else if (r_state == S_HIGH && w_expired) begin
        r_state <= S_LOW;
        r_cnt   <= c_LOW_LD;
        PUL     <= 1'b0;
      end else if (r_state == S_LOW && w_expired) begin
        // Only reachable with ena_in low: the run ends after a full period.
        r_state <= S_IDLE;
        ENA     <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // A clear wins over a coincident step; that step is not counted.
      if (pos_clr) begin
        position <= '0;
      end else if (w_to_high) begin
        position <= DIR ? (position + c_ONE) : (position - c_ONE);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_pulse_gen
// Brief    : Self-checking bench for step_pulse_gen using a step scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_pulse_gen;

  localparam int PERIOD    = 8;
  localparam int PUL_HIGH  = 3;
  localparam int DIR_SETUP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena_in = 1'b0;
  logic dir_in = 1'b0;
  logic pos_clr = 1'b0;

  logic ENA, DIR, PUL, step_stb;
  logic signed [23:0] position;
  logic ENA_n, DIR_n, PUL_n, stb_n;
  logic signed [3:0] position_n;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int hi_len = 0;

  typedef struct {
    int   edge_n;
    logic dir;
    int   pos;
  } step_t;

  step_t sb[$];
  step_t s;

  step_pulse_gen #(.PERIOD(PERIOD), .PUL_HIGH(PUL_HIGH), .DIR_SETUP(DIR_SETUP), .POS_W(24)) dut (
    .clk(clk), .rst(rst), .ena_in(ena_in), .dir_in(dir_in), .pos_clr(pos_clr),
    .ENA(ENA), .DIR(DIR), .PUL(PUL), .step_stb(step_stb), .position(position)
  );

  step_pulse_gen #(.PERIOD(PERIOD), .PUL_HIGH(PUL_HIGH), .DIR_SETUP(DIR_SETUP), .POS_W(4)) dut_n (
    .clk(clk), .rst(rst), .ena_in(ena_in), .dir_in(dir_in), .pos_clr(pos_clr),
    .ENA(ENA_n), .DIR(DIR_n), .PUL(PUL_n), .step_stb(stb_n), .position(position_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: each strobe must match the next expected step.
  always @(posedge clk) begin
    #1;
    if (!rst && step_stb) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step edge=%0d position=%0d", cyc, position);
      end else begin
        s = sb.pop_front();
        if (cyc !== s.edge_n || DIR !== s.dir || position !== 24'(s.pos) ||
            position_n !== 4'(s.pos) || PUL !== 1'b1 || PUL_n !== 1'b1 ||
            stb_n !== 1'b1 || DIR_n !== s.dir) begin
          errors++;
          $display("FAIL step edge=%0d/%0d dir=%b/%b pos=%0d/%0d pos_n=%0d/%0d pul=%b stb_n=%b",
                   cyc, s.edge_n, DIR, s.dir, position, 24'(s.pos),
                   position_n, 4'(s.pos), PUL, stb_n);
        end
      end
    end
  end

  // Every completed pulse must be exactly PUL_HIGH cycles wide.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      hi_len = 0;
    end else if (PUL) begin
      hi_len++;
    end else if (hi_len != 0) begin
      checks++;
      if (hi_len !== PUL_HIGH) begin
        errors++;
        $display("FAIL pul_width got=%0d want=%0d", hi_len, PUL_HIGH);
      end
      hi_len = 0;
    end
  end

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic push_step(input int e, input logic d, input int p);
    step_t t;
    t.edge_n = e;
    t.dir    = d;
    t.pos    = p;
    sb.push_back(t);
  endtask

  task automatic pulse_clr();
    pos_clr = 1'b1;
    @(negedge clk);
    pos_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({PUL, DIR, ENA, step_stb} !== 4'b0000 || position !== 24'sd0 || position_n !== 4'sd0 ||
        {PUL_n, DIR_n, ENA_n, stb_n} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state pul=%b dir=%b ena=%b stb=%b pos=%0d pos_n=%0d want all 0",
               PUL, DIR, ENA, step_stb, position, position_n);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ENA !== 1'b0 || PUL !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset ena=%b pul=%b want 0 0", ENA, PUL);
    end
  endtask

  task automatic test_basic_reverse(inout int p);
    int k;
    ena_in = 1'b1;
    dir_in = 1'b0;
    k = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      p = p - 1;
      push_step(k + i * PERIOD, 1'b0, p);
    end
    wait_to(k + 31);
    checks++;
    if (ENA !== 1'b1) begin
      errors++;
      $display("FAIL basic_ena_running got=%b want 1", ENA);
    end
    ena_in = 1'b0;
    wait_to(k + 32);
    checks++;
    if (ENA !== 1'b0 || PUL !== 1'b0 || ENA_n !== 1'b0) begin
      errors++;
      $display("FAIL basic_ena_drop ena=%b pul=%b want 0 0", ENA, PUL);
    end
    checks++;
    if (position !== -24'sd4 || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_position got=%0d want -4 pending=%0d", position, sb.size());
    end
  endtask

  task automatic test_reversal(inout int p);
    int k;
    ena_in = 1'b1;
    dir_in = 1'b1;
    k = cyc + 1;
    push_step(k + 2, 1'b1, p + 1);
    push_step(k + 10, 1'b1, p + 2);
    push_step(k + 20, 1'b0, p + 1);
    p = p + 1;
    wait_to(k);
    checks++;
    if (DIR !== 1'b1 || ENA !== 1'b1 || PUL !== 1'b0) begin
      errors++;
      $display("FAIL rev_setup_entry dir=%b ena=%b pul=%b want 1 1 0", DIR, ENA, PUL);
    end
    wait_to(k + 10);
    dir_in = 1'b0;
    wait_to(k + 17);
    checks++;
    if (DIR !== 1'b1) begin
      errors++;
      $display("FAIL rev_dir_held_in_low got=%b want 1", DIR);
    end
    wait_to(k + 18);
    checks++;
    if (DIR !== 1'b0 || PUL !== 1'b0 || ENA !== 1'b1) begin
      errors++;
      $display("FAIL rev_dir_change dir=%b pul=%b ena=%b want 0 0 1", DIR, PUL, ENA);
    end
    wait_to(k + 20);
    ena_in = 1'b0;
    wait_to(k + 28);
    checks++;
    if (ENA !== 1'b0 || sb.size() != 0 || position !== 24'(p)) begin
      errors++;
      $display("FAIL rev_end ena=%b pending=%0d pos=%0d want 0 0 %0d", ENA, sb.size(), position, p);
    end
  endtask

  task automatic test_early_stop(inout int p);
    int k;
    int n;
    pulse_clr();
    p = 0;
    checks++;
    if (position !== 24'sd0) begin
      errors++;
      $display("FAIL early_clr got=%0d want 0", position);
    end
    for (int r = 0; r < 2; r++) begin
      ena_in = 1'b1;
      dir_in = 1'b1;
      k = cyc + 1;
      p = p + 1;
      push_step(k + ((r == 0) ? DIR_SETUP : 0), 1'b1, p);
      @(negedge clk);
      ena_in = 1'b0;
      n = 0;
      while (ENA === 1'b1 && n < 40) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n !== ((r == 0) ? DIR_SETUP + PERIOD : PERIOD) || sb.size() != 0 || position !== 24'(p)) begin
        errors++;
        $display("FAIL early_stop_%0d ena_cycles=%0d want %0d pending=%0d pos=%0d want %0d",
                 r, n, (r == 0) ? DIR_SETUP + PERIOD : PERIOD, sb.size(), position, p);
      end
    end
  endtask

  task automatic test_wrap(inout int p);
    int k;
    int n;
    pulse_clr();
    p = 0;
    ena_in = 1'b1;
    dir_in = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      p = p + 1;
      push_step(k + i * PERIOD, 1'b1, p);
    end
    wait_to(k + 63);
    ena_in = 1'b0;
    wait_to(k + 64);
    checks++;
    if (position_n !== -4'sd8 || position !== 24'sd8 || ENA_n !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_fwd pos_n=%0d want -8 pos=%0d want 8 ena_n=%b pending=%0d",
               position_n, position, ENA_n, sb.size());
    end
    pulse_clr();
    p = 0;
    ena_in = 1'b1;
    dir_in = 1'b0;
    k = cyc + 1;
    p = -1;
    push_step(k + DIR_SETUP, 1'b0, p);
    @(negedge clk);
    ena_in = 1'b0;
    n = 0;
    while (ENA === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (position_n !== 4'shF || position !== -24'sd1 || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_rev pos_n=%h want f pos=%0d want -1 pending=%0d", position_n, position, sb.size());
    end
  endtask

  task automatic test_clr_vs_step(inout int p);
    int k;
    pulse_clr();
    p = 0;
    ena_in = 1'b1;
    dir_in = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 5; i++) push_step(k + DIR_SETUP + i * PERIOD, 1'b1, i + 1);
    push_step(k + DIR_SETUP + 5 * PERIOD, 1'b1, 0);
    push_step(k + DIR_SETUP + 6 * PERIOD, 1'b1, 1);
    p = 1;
    wait_to(k + DIR_SETUP + 5 * PERIOD - 1);
    checks++;
    if (position !== 24'sd5) begin
      errors++;
      $display("FAIL clr_pre_position got=%0d want 5", position);
    end
    pulse_clr();
    checks++;
    if (position !== 24'sd0 || step_stb !== 1'b1) begin
      errors++;
      $display("FAIL clr_coincident pos=%0d stb=%b want 0 1", position, step_stb);
    end
    wait_to(k + DIR_SETUP + 6 * PERIOD);
    ena_in = 1'b0;
    wait_to(k + DIR_SETUP + 7 * PERIOD);
    checks++;
    if (ENA !== 1'b0 || position !== 24'sd1 || sb.size() != 0) begin
      errors++;
      $display("FAIL clr_after ena=%b pos=%0d want 0 1 pending=%0d", ENA, position, sb.size());
    end
  endtask

  task automatic test_async_reset(inout int p);
    int k;
    ena_in = 1'b1;
    dir_in = 1'b1;
    k = cyc + 1;
    push_step(k, 1'b1, p + 1);
    wait_to(k);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({PUL, ENA, DIR, step_stb} !== 4'b0000 || position !== 24'sd0 || position_n !== 4'sd0) begin
      errors++;
      $display("FAIL async_reset pul=%b ena=%b dir=%b stb=%b pos=%0d want all 0",
               PUL, ENA, DIR, step_stb, position);
    end
    @(negedge clk);
    dir_in = 1'b0;
    rst = 1'b0;
    k = cyc + 1;
    p = -1;
    push_step(k, 1'b0, p);
    wait_to(k);
    checks++;
    if (PUL !== 1'b1 || ENA !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_first_rise pul=%b ena=%b want 1 1", PUL, ENA);
    end
    ena_in = 1'b0;
    wait_to(k + PERIOD);
    checks++;
    if (ENA !== 1'b0 || sb.size() != 0 || position !== -24'sd1) begin
      errors++;
      $display("FAIL post_reset_end ena=%b pending=%0d pos=%0d want 0 0 -1", ENA, sb.size(), position);
    end
  endtask

  initial begin
    int p;
    p = 0;
    test_reset();
    test_basic_reverse(p);
    test_reversal(p);
    test_early_stop(p);
    test_wrap(p);
    test_clr_vs_step(p);
    test_async_reset(p);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
